field_capture_fifo: RTL
=======================

Name: field_capture_fifo

Overview:
Parametrised successor to the team's single-entry opcode capture register. It extracts a configurable bit field from each accepted input word and buffers up to DEPTH fields in a small FIFO. Transfers on both sides use a valid/ready handshake, and the FIFO supports a synchronous flush. It sits between the instruction/switch input stage and the ALU/display control path, so that bursts of operations are not lost while the consumer is busy.

Parameters:
DATA_W, 5, width of the input word.
FIELD_LSB, 0, LSB position of the extracted field within in_data.
FIELD_W, 3, width of the extracted field; FIELD_LSB+FIELD_W <= DATA_W.
DEPTH, 4, number of FIFO entries; power of 2, >= 2.
AF_LEVEL, 3, occupancy at or above which almost_full asserts; 1 <= AF_LEVEL <= DEPTH.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active-low.
flush  in  1  synchronous clear of FIFO contents.
in_valid  in  1  producer offers in_data.
in_ready  out  1  FIFO can accept a word this cycle.
in_data  in  DATA_W  input word.
out_valid  out  1  head entry is valid.
out_ready  in  1  consumer takes the head entry this cycle.
out_field  out  FIELD_W  head entry, in_data[FIELD_LSB +: FIELD_W] as captured.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
almost_full  out  1  count >= AF_LEVEL.

Behaviour:
- Clock and reset: single clock domain. rst_n is sampled on the rising edge of clk, synchronous and active-low.
- Reset values: count=0, out_valid=0, in_ready=1, almost_full=0, out_field=0. Read and write pointers are 0. Storage is cleared to 0.
- Push: occurs when in_valid && in_ready. The entry written is in_data[FIELD_LSB +: FIELD_W]; bits outside the field are ignored.
- Pop: occurs when out_valid && out_ready.
- Readiness:
  - in_ready = (count != DEPTH), derived from registered state only.
  - There is no combinational path from out_ready to in_ready. When full, a push is refused even if a pop happens in the same cycle.
- Latency: a word pushed at edge N is visible on out_valid/out_field after edge N (next cycle). There is no same-cycle fall-through.
- out_field:
  - Driven from storage at the read pointer.
  - Forced to 0 whenever out_valid=0.
  - Stable while out_valid=1 && out_ready=0.
- Occupancy per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together (only possible when 0 < count < DEPTH): count unchanged; the head advances and the new entry is written at the tail.
- Empty: out_valid=0. out_ready is ignored. A push while empty sets out_valid=1 on the next cycle.
- Full: in_ready=0. in_valid is ignored, with no overwrite and no error flag. The producer must hold its word.
- Pointers: $clog2(DEPTH)+1 bits each. They wrap modulo 2*DEPTH, and the low bits index storage. Full/empty may be derived from the pointers or from count; both must agree with count.
- flush (priority below reset, above push/pop):
  - Next cycle: count=0, pointers=0, out_valid=0, in_ready=1.
  - A push or pop presented in the flush cycle is discarded.
  - Storage contents need not be cleared.
- Reset mid-operation: any buffered data is discarded. No output may glitch to a stale value after the reset edge; out_field=0.
- almost_full: registered and consistent with count each cycle.

Decomposition:
- Shared package field_capture_pkg:
  - default-parameter constants (DATA_W/FIELD_W/DEPTH defaults);
  - a function computing pointer width from DEPTH;
  - a typedef for the count type.
- One sub-module: fifo_ptr_ctrl. It holds the pointers, count, full/empty, almost_full, and push/pop/flush arbitration.
- The top-level field_capture_fifo holds field extraction, storage, and output muxing.
- Elaboration-time assertions check the parameter legality rules above.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with in_valid=1, in_data=5'b10110 -> count=0, out_valid=0, out_field=0, in_ready=1; no entry is stored after release.
- Field extraction (DATA_W=5, FIELD_LSB=0, FIELD_W=3): push 5'b11101 with out_ready=0, then raise out_ready -> out_valid=1 one cycle after the push, out_field=3'b101; after the pop, out_valid=0 and out_field=0.
- Fill, order and wrap:
  - Push 1,2,3,4 with out_ready=0 -> count=4, in_ready=0, almost_full=1 from count=3.
  - Push 5 while full -> refused, count stays 4.
  - Drain -> out_field order 1,2,3,4.
  - Repeat twice to exercise pointer wrap.
- Simultaneous push/pop: at count=2, push 6 and pop in the same cycle -> count stays 2, the head advances, and 6 is emitted after the older entry.
- Full boundary: at count=4, assert in_valid=1 and out_ready=1 together -> the pop happens, the push is refused, count=3, in_ready=1 on the next cycle.
- Flush and mid-operation reset:
  - At count=3, flush=1 with a simultaneous push -> next cycle count=0, out_valid=0, in_ready=1, and the pushed word is absent.
  - Repeat with rst_n=0 instead of flush -> same result, and out_field=0.

Source files
------------

// File: rtl/field_capture_pkg.sv
// field_capture_pkg
// Shared defaults and helpers for field_capture_fifo and its pointer controller.
//   DEF_*        : default parameter values for the FIFO
//   ptr_width()  : pointer/count width for a given depth (one extra wrap bit)
//   def_count_t  : occupancy type for the default depth
package field_capture_pkg;

    localparam int unsigned DEF_DATA_W    = 5;
    localparam int unsigned DEF_FIELD_LSB = 0;
    localparam int unsigned DEF_FIELD_W   = 3;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_AF_LEVEL  = 3;

    // One bit beyond the index width so pointers wrap modulo 2*DEPTH and
    // the count can represent the full value DEPTH.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_PTR_W = $clog2(DEF_DEPTH) + 1;

    typedef logic [DEF_PTR_W-1:0] def_count_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Pointer, occupancy and handshake control for field_capture_fifo.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush_i        : synchronous clear; discards any push/pop in the same cycle
//   push_req_i     : producer offers a word (in_valid)
//   pop_req_i      : consumer takes the head (out_ready)
//   wr_en_o        : storage write strobe for this cycle
//   wr_idx_o       : storage index for the write
//   rd_idx_o       : storage index of the head entry
//   count_o        : occupancy 0..DEPTH
//   in_ready_o     : not full (registered state only)
//   out_valid_o    : not empty (registered state only)
//   almost_full_o  : registered count >= AF_LEVEL
module fifo_ptr_ctrl
    import field_capture_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    localparam int unsigned PW      = ptr_width(DEPTH),
    localparam int unsigned IW      = PW - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_req_i,
    input  logic          pop_req_i,
    output logic          wr_en_o,
    output logic [IW-1:0] wr_idx_o,
    output logic [IW-1:0] rd_idx_o,
    output logic [PW-1:0] count_o,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic          almost_full_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          af_q, af_d;
    logic          full, empty, push, pop;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never opens the input side combinationally.
    assign full  = (count_q == PW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = push_req_i && !full;
    assign pop   = pop_req_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
        af_d = (count_d >= PW'(AF_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_q     <= af_d;
        end
    end

    assign wr_en_o       = push && !flush_i;
    assign wr_idx_o      = wr_ptr_q[IW-1:0];
    assign rd_idx_o      = rd_ptr_q[IW-1:0];
    assign count_o       = count_q;
    assign in_ready_o    = !full;
    assign out_valid_o   = !empty;
    assign almost_full_o = af_q;

    // Pointer distance and count are tracked separately; they must agree.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_ptr_q - rd_ptr_q) == count_q);

endmodule

// File: rtl/field_capture_fifo.sv
// field_capture_fifo
// Extracts in_data[FIELD_LSB +: FIELD_W] from each accepted word and buffers
// up to DEPTH fields with valid/ready handshakes on both sides.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : synchronous clear of FIFO contents
//   in_valid/in_ready/in_data      : producer handshake and word
//   out_valid/out_ready/out_field  : consumer handshake and head field
//   count        : occupancy 0..DEPTH
//   almost_full  : count >= AF_LEVEL (registered)
module field_capture_fifo
    import field_capture_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FIELD_LSB = DEF_FIELD_LSB,
    parameter int unsigned FIELD_W   = DEF_FIELD_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_LEVEL  = DEF_AF_LEVEL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_W-1:0]     out_field,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int unsigned IW = $clog2(DEPTH);

    if (FIELD_W < 1 || FIELD_LSB + FIELD_W > DATA_W) begin : g_bad_field
        $error("field_capture_fifo: field [%0d +: %0d] outside DATA_W=%0d",
               FIELD_LSB, FIELD_W, DATA_W);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("field_capture_fifo: DEPTH=%0d must be a power of 2 >= 2", DEPTH);
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("field_capture_fifo: AF_LEVEL=%0d must be in 1..DEPTH", AF_LEVEL);
    end

    logic               wr_en;
    logic [IW-1:0]      wr_idx, rd_idx;
    logic [FIELD_W-1:0] field_in;
    logic [FIELD_W-1:0] mem_q [DEPTH];

    // Bits outside the field are intentionally dropped.
    logic unused_in_bits;
    assign unused_in_bits = ^in_data;

    assign field_in = in_data[FIELD_LSB +: FIELD_W];

    fifo_ptr_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .push_req_i    (in_valid),
        .pop_req_i     (out_ready),
        .wr_en_o       (wr_en),
        .wr_idx_o      (wr_idx),
        .rd_idx_o      (rd_idx),
        .count_o       (count),
        .in_ready_o    (in_ready),
        .out_valid_o   (out_valid),
        .almost_full_o (almost_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= field_in;
        end
    end

    // Head is only presented while valid so stale storage never leaks out.
    assign out_field = out_valid ? mem_q[rd_idx] : '0;

endmodule
